bot_update_handshake: RTL
=========================

// Module: bot_update_handshake
//
// PURPOSE
//   Upstream stage between the rojobot31_0 system-register outputs and the mfp_sys
//   H_BOT_* inputs. Replaces the ad-hoc set/clear flip-flop.
//   On each upd_sysregs rising edge it snapshots {LocX,LocY,Sensors,BotInfo}, holds the
//   snapshot stable, and raises bot_update_sync until the CPU acknowledges it.
//   A one-deep shadow buffer holds an update that arrives mid-handshake; overruns are counted.
//
// PARAMETERS
//   DATA_W     32  width of packed bot info {LocX,LocY,Sensors,BotInfo}
//   UPD_CNT_W  16  width of the free-running update counter (wraps)
//   OVR_CNT_W   8  width of the overrun counter (saturates)
//
// PORTS
//   clk            in   1          single clock; every register is on its rising edge
//   reset          in   1          synchronous, active-high
//   upd_sysregs    in   1          rojobot register-update strobe (level; edge detected here)
//   bot_info_in    in   DATA_W     live {LocX_reg,LocY_reg,Sensors_reg,BotInfo_reg}
//   int_ack        in   1          CPU acknowledge (level, from H_INT_ACK)
//   bot_info_out   out  DATA_W     stable snapshot -> H_BOT_INFO
//   bot_update_sync out 1          update-pending flag -> H_BOT_UPDATE_SYNC
//   upd_count      out  UPD_CNT_W  number of upd_sysregs rising edges seen
//   overrun_count  out  OVR_CNT_W  updates lost (shadow overwritten), saturating
//   shadow_valid   out  1          shadow buffer occupied
//
// BEHAVIOUR
//   - Reset: state=IDLE. bot_info_out=0, bot_update_sync=0, upd_count=0, overrun_count=0,
//     shadow_valid=0, upd_d=0.
//   - upd_rise = upd_sysregs & ~upd_d. upd_d is registered every cycle.
//     A held-high strobe counts once. upd_count increments (wraps) on every upd_rise.
//   - FSM, all outputs registered:
//     IDLE:     upd_rise -> load bot_info_out<=bot_info_in, go PENDING.
//               Sync is visible 1 cycle after upd_sysregs is first sampled high.
//               int_ack is ignored in IDLE.
//     PENDING:  sync=1, bot_info_out frozen. int_ack=1 -> ACK_WAIT (sync=0 next cycle).
//     ACK_WAIT: sync=0. Stays here while int_ack=1 (no re-trigger on a held ack).
//               int_ack=0 and shadow_valid=1 -> bot_info_out<=shadow, clear shadow, go PENDING.
//               int_ack=0 and shadow_valid=0 -> IDLE.
//   - Shadow: upd_rise in PENDING or ACK_WAIT -> shadow<=bot_info_in, shadow_valid<=1.
//     If shadow_valid was already 1: shadow is overwritten with the newest data and
//     overwritten with the newest data and overrun_count+1, saturating at all-ones.
//   - Simultaneous events:
//     upd_rise + int_ack in PENDING: state -> ACK_WAIT and data -> shadow.
//     upd_rise in the ACK_WAIT cycle that drains the shadow: out<=old shadow,
//       shadow<=bot_info_in, shadow_valid stays 1, no overrun.
//   - reset asserted mid-handshake: everything returns to reset values on that edge,
//     and the pending update is discarded.
//   - Latency upd_rise -> sync: 1 cycle. ack low -> next pending (shadow case): 1 cycle.
//
// STRUCTURE
//   - Shared header bot_if_const.vh (`include, alongside mfp_ahb_const.vh):
//       state encodings BHS_IDLE=2'd0, BHS_PENDING=2'd1, BHS_ACK_WAIT=2'd2;
//       bit-field positions of LocX/LocY/Sensors/BotInfo within DATA_W.
//   - One sub-module: rise_detect (1-bit register + AND) producing upd_rise.
//     FSM, shadow and counters stay in this module.
//
// TESTING
//   - Reset, then upd pulse with info=32'h1234_5678:
//       1 cycle later sync=1, out=32'h1234_5678; ack 1 cycle -> sync=0; back to IDLE.
//   - upd held high 10 cycles: upd_count +1 only, a single handshake.
//   - In PENDING, upd with info=32'hAAAA_0001 then ack pulse:
//       sync low while ack=1; after ack falls, out=32'hAAAA_0001 and sync=1 one cycle later.
//   - Three updates during one PENDING: overrun_count=2, shadow holds the third value.
//     Also force overrun_count to 8'hFF plus one more overrun -> stays 8'hFF.
//   - upd_rise and ack on the same cycle in PENDING:
//       shadow_valid=1, no overrun, the next PENDING presents the new data.
//   - reset asserted while in PENDING with shadow_valid=1:
//       all outputs 0 next cycle, and a later ack has no effect.

Source files
------------

// File: rtl/bot_update_handshake_pkg.sv
// Shared types and field layout for the rojobot update handshake.
// Holds the state encoding and the bit positions of the packed bot info word.
package bot_update_handshake_pkg;

    typedef enum logic [1:0] {
        BHS_IDLE     = 2'd0,
        BHS_PENDING  = 2'd1,
        BHS_ACK_WAIT = 2'd2
    } bhs_state_t;

    // Packed word layout: {LocX, LocY, Sensors, BotInfo}, one byte each
    localparam int LOCX_LSB    = 24;
    localparam int LOCY_LSB    = 16;
    localparam int SENSORS_LSB = 8;
    localparam int BOTINFO_LSB = 0;
    localparam int FIELD_W     = 8;

    function automatic logic [31:0] pack_bot_info(
        input logic [7:0] loc_x,
        input logic [7:0] loc_y,
        input logic [7:0] sensors,
        input logic [7:0] bot_info
    );
        return {loc_x, loc_y, sensors, bot_info};
    endfunction

endpackage

// File: rtl/bot_update_handshake_rise_detect.sv
// Rising-edge detector for the rojobot register-update strobe.
module bot_update_handshake_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk) begin
        if (reset)
            sig_d <= 1'b0;
        else
            sig_d <= sig;
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/bot_update_handshake.sv
// Snapshots rojobot register updates and hands them to the CPU with a level
// handshake; a one-deep shadow keeps an update that lands mid-handshake.
module bot_update_handshake
    import bot_update_handshake_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int UPD_CNT_W = 16,
    parameter int OVR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 upd_sysregs,
    input  logic [DATA_W-1:0]    bot_info_in,
    input  logic                 int_ack,
    output logic [DATA_W-1:0]    bot_info_out,
    output logic                 bot_update_sync,
    output logic [UPD_CNT_W-1:0] upd_count,
    output logic [OVR_CNT_W-1:0] overrun_count,
    output logic                 shadow_valid
);

    bhs_state_t        state;
    bhs_state_t        next_state;
    logic              upd_rise;
    logic [DATA_W-1:0] shadow;
    logic              load_direct;
    logic              drain_shadow;
    logic              capture_shadow;

    bot_update_handshake_rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .sig   (upd_sysregs),
        .rise  (upd_rise)
    );

    // An update arriving while the CPU still owns the current snapshot goes to the shadow
    always_comb begin
        next_state     = state;
        load_direct    = 1'b0;
        drain_shadow   = 1'b0;
        capture_shadow = 1'b0;
        case (state)
            BHS_IDLE: begin
                if (upd_rise) begin
                    load_direct = 1'b1;
                    next_state  = BHS_PENDING;
                end
            end
            BHS_PENDING: begin
                capture_shadow = upd_rise;
                if (int_ack)
                    next_state = BHS_ACK_WAIT;
            end
            BHS_ACK_WAIT: begin
                capture_shadow = upd_rise;
                if (!int_ack) begin
                    if (shadow_valid) begin
                        drain_shadow = 1'b1;
                        next_state   = BHS_PENDING;
                    end else begin
                        next_state = BHS_IDLE;
                    end
                end
            end
            default: next_state = BHS_IDLE;
        endcase
    end

    // Draining and refilling the shadow on the same edge is not a loss, so no overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= BHS_IDLE;
            bot_info_out    <= '0;
            bot_update_sync <= 1'b0;
            upd_count       <= '0;
            overrun_count   <= '0;
            shadow_valid    <= 1'b0;
            shadow          <= '0;
        end else begin
            state           <= next_state;
            bot_update_sync <= (next_state == BHS_PENDING);
            if (upd_rise)
                upd_count <= upd_count + UPD_CNT_W'(1);
            if (load_direct)
                bot_info_out <= bot_info_in;
            else if (drain_shadow)
                bot_info_out <= shadow;
            if (capture_shadow) begin
                shadow       <= bot_info_in;
                shadow_valid <= 1'b1;
                if (shadow_valid && !drain_shadow && (overrun_count != '1))
                    overrun_count <= overrun_count + OVR_CNT_W'(1);
            end else if (drain_shadow) begin
                shadow_valid <= 1'b0;
            end
        end
    end

endmodule
